// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the pipeline control slice.
// Holds the sequencer state enum, the default register-index width used by
// both the decoder and the hazard logic, and a packed bundle of the five
// per-stage register enables.
package cpu_ctrl_pkg;

    // Register fields in the decoder are 3 bits wide (r0..r7).
    localparam int DEFAULT_REG_ADDR_W = 3;

    typedef enum logic [2:0] {
        S_RESET    = 3'd0,
        S_RUN      = 3'd1,
        S_MEM_WAIT = 3'd2,
        S_DRAIN    = 3'd3,
        S_HALT     = 3'd4
    } ctrl_state_t;

    // Field order matches pipe order, oldest stage last.
    typedef struct packed {
        logic fetch;
        logic decode;
        logic exec;
        logic mem;
        logic wb;
    } stage_en_t;

    localparam stage_en_t EN_NONE = '0;
    localparam stage_en_t EN_ALL  = '1;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in execute is a register-writing load whose
// destination matches a source register actually read by the instruction in
// decode. Stage-valid qualification is left to the caller.
//
// Ports:
//   dec_reg1, dec_reg2 : decode source register indices
//   dec_use1, dec_use2 : the matching source is really read
//   ex_mem_read        : execute holds a load
//   ex_reg_write       : execute writes a register
//   ex_reg_dest        : destination register of the execute instruction
//   load_use           : hazard present
module hazard_detect
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] dec_reg1,
    input  logic [REG_ADDR_W-1:0] dec_reg2,
    input  logic                  dec_use1,
    input  logic                  dec_use2,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic [REG_ADDR_W-1:0] ex_reg_dest,
    output logic                  load_use
);

    logic src1Match;
    logic src2Match;

    // Only sources that are really read can create a dependency; immediate
    // and PC operands are masked off by the use flags.
    assign src1Match = dec_use1 && (dec_reg1 == ex_reg_dest);
    assign src2Match = dec_use2 && (dec_reg2 == ex_reg_dest);

    assign load_use = ex_mem_read && ex_reg_write && (src1Match || src2Match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central sequencer for the five-stage integer pipeline.
// Produces the per-stage register enables and the PC-load strobe, tracks a
// valid bit for the decode/execute/memory/writeback stages, inserts a bubble
// on load-use hazards, flushes younger stages on a taken branch, freezes the
// pipe while data memory is busy, and drains the pipe on a halt request.
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   if_valid                       : fetch presents a valid instruction
//   dec_reg1/2, dec_use1/2         : decode source registers and use flags
//   ex_mem_read, ex_reg_write      : execute instruction is a load / writes
//   ex_reg_dest                    : execute destination register
//   ex_branch_taken                : execute resolved a taken branch/jump
//   mem_busy                       : data memory stalls this cycle
//   halt_req                       : level request to stop and drain
//   fetch_en..wb_en, pc_load       : combinational stage enables, PC load
//   dec_valid..wb_valid            : registered stage-valid bits
//   halted                         : registered, pipe empty and stopped
//   stall_count                    : saturating freeze/bubble cycle count
module pipeline_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = DEFAULT_REG_ADDR_W,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_valid,
    input  logic [REG_ADDR_W-1:0]  dec_reg1,
    input  logic [REG_ADDR_W-1:0]  dec_reg2,
    input  logic                   dec_use1,
    input  logic                   dec_use2,
    input  logic                   ex_mem_read,
    input  logic                   ex_reg_write,
    input  logic [REG_ADDR_W-1:0]  ex_reg_dest,
    input  logic                   ex_branch_taken,
    input  logic                   mem_busy,
    input  logic                   halt_req,
    output logic                   fetch_en,
    output logic                   decode_en,
    output logic                   exec_en,
    output logic                   mem_en,
    output logic                   wb_en,
    output logic                   pc_load,
    output logic                   dec_valid,
    output logic                   ex_valid,
    output logic                   mem_valid,
    output logic                   wb_valid,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [STALL_CNT_W-1:0] CntOne = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    ctrl_state_t state;
    ctrl_state_t nextState;
    stage_en_t   stageEn;
    logic        pcLoad;
    logic        hazardRaw;
    logic        flushNow;
    logic        bubbleNow;
    logic        draining;
    logic        pipeEmpty;
    logic        countStall;
    logic        nextDec;
    logic        nextEx;
    logic        nextMem;
    logic        nextWb;

    hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) uHazard (
        .dec_reg1     (dec_reg1),
        .dec_reg2     (dec_reg2),
        .dec_use1     (dec_use1),
        .dec_use2     (dec_use2),
        .ex_mem_read  (ex_mem_read),
        .ex_reg_write (ex_reg_write),
        .ex_reg_dest  (ex_reg_dest),
        .load_use     (hazardRaw)
    );

    // A taken branch only counts when execute really holds an instruction.
    // The hazard is ignored during a flush because decode is being killed.
    assign flushNow  = ex_valid && ex_branch_taken;
    assign bubbleNow = hazardRaw && dec_valid && ex_valid && !flushNow;

    // Fetch is shut off from the very cycle halt_req is seen in S_RUN, so a
    // halt during S_MEM_WAIT waits for the return to S_RUN.
    assign draining  = (state == S_DRAIN) || ((state == S_RUN) && halt_req);
    assign pipeEmpty = !(dec_valid || ex_valid || mem_valid || wb_valid);

    // Priority mux: freeze > flush > load-use bubble > advance. Holding the
    // valid bits by default makes the freeze case fall out naturally. A
    // freeze while draining stays in S_DRAIN so fetch never re-opens before
    // the halt completes.
    always_comb begin
        nextState  = state;
        stageEn    = EN_NONE;
        pcLoad     = 1'b0;
        countStall = 1'b0;
        nextDec    = dec_valid;
        nextEx     = ex_valid;
        nextMem    = mem_valid;
        nextWb     = wb_valid;

        case (state)
            S_RESET: begin
                nextState = S_RUN;
            end

            S_RUN, S_MEM_WAIT, S_DRAIN: begin
                if (mem_busy) begin
                    countStall = 1'b1;
                end else if (flushNow) begin
                    stageEn = EN_ALL;
                    pcLoad  = 1'b1;
                    nextDec = 1'b0;
                    nextEx  = 1'b0;
                    nextMem = ex_valid;
                    nextWb  = mem_valid;
                end else if (bubbleNow) begin
                    stageEn        = EN_ALL;
                    stageEn.fetch  = 1'b0;
                    stageEn.decode = 1'b0;
                    countStall     = 1'b1;
                    nextEx         = 1'b0;
                    nextMem        = ex_valid;
                    nextWb         = mem_valid;
                end else begin
                    stageEn = EN_ALL;
                    nextDec = if_valid && !draining;
                    nextEx  = dec_valid;
                    nextMem = ex_valid;
                    nextWb  = mem_valid;
                end

                if (draining) begin
                    stageEn.fetch = 1'b0;
                end

                if (state == S_DRAIN) begin
                    nextState = pipeEmpty ? S_HALT : S_DRAIN;
                end else if (mem_busy) begin
                    nextState = S_MEM_WAIT;
                end else if ((state == S_RUN) && halt_req) begin
                    nextState = S_DRAIN;
                end else begin
                    nextState = S_RUN;
                end
            end

            S_HALT: begin
                if (!halt_req) begin
                    nextState = S_RUN;
                end
            end

            default: begin
                nextState = S_RESET;
            end
        endcase

        // Enables stay low for the whole time reset is held, whatever state
        // the register happens to be in.
        if (rst) begin
            stageEn = EN_NONE;
            pcLoad  = 1'b0;
        end
    end

    assign fetch_en  = stageEn.fetch;
    assign decode_en = stageEn.decode;
    assign exec_en   = stageEn.exec;
    assign mem_en    = stageEn.mem;
    assign wb_en     = stageEn.wb;
    assign pc_load   = pcLoad;

    // State, valid chain, halted flag and saturating stall counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_RESET;
            dec_valid   <= 1'b0;
            ex_valid    <= 1'b0;
            mem_valid   <= 1'b0;
            wb_valid    <= 1'b0;
            halted      <= 1'b0;
            stall_count <= '0;
        end else begin
            state     <= nextState;
            dec_valid <= nextDec;
            ex_valid  <= nextEx;
            mem_valid <= nextMem;
            wb_valid  <= nextWb;
            halted    <= (nextState == S_HALT);
            if (countStall && (stall_count != '1)) begin
                stall_count <= stall_count + CntOne;
            end
        end
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage integer pipeline (fetch, decode, execute, memory, writeback). It generates the per-stage register enables that gate each stage's `en` input, including the decode stage. It tracks a valid bit per stage, inserts bubbles on load-use hazards, and flushes younger stages on a taken branch. It also freezes the whole pipe while data memory is busy and drains the pipe on a halt request.

## Interface

Parameters:
- `REG_ADDR_W`, default 3: register-index width, matching the decoder's 3-bit register fields.
- `STALL_CNT_W`, default 16: width of the saturating stall-cycle counter.

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `if_valid`, in, 1: fetch stage is presenting a valid instruction word this cycle.
- `dec_reg1`, `dec_reg2`, in, REG_ADDR_W each: ALU source registers of the instruction in decode.
- `dec_use1`, `dec_use2`, in, 1 each: the corresponding source register is actually read (not an immediate or PC source).
- `ex_mem_read`, in, 1: the instruction in execute is a byte or word load.
- `ex_reg_write`, in, 1: the instruction in execute writes a register.
- `ex_reg_dest`, in, REG_ADDR_W: destination register of the instruction in execute.
- `ex_branch_taken`, in, 1: execute resolved a taken branch or jump this cycle; qualified internally by `ex_valid`.
- `mem_busy`, in, 1: data memory cannot complete this cycle.
- `halt_req`, in, 1: level request to stop fetching and drain.
- `fetch_en`, `decode_en`, `exec_en`, `mem_en`, `wb_en`, out, 1 each: stage register enables (combinational).
- `pc_load`, out, 1: load the branch target into the PC (combinational).
- `dec_valid`, `ex_valid`, `mem_valid`, `wb_valid`, out, 1 each: registered stage-valid bits.
- `halted`, out, 1: registered; pipe is empty and stopped.
- `stall_count`, out, STALL_CNT_W: registered count of freeze and bubble cycles, saturating.

## Operation

States:
- **S_RESET**: one cycle after `rst` deasserts; all enables 0; always goes to S_RUN.
- **S_RUN**: normal issue.
- **S_MEM_WAIT**: entered when `mem_busy` is 1; returns to S_RUN on the first cycle `mem_busy` is 0.
- **S_DRAIN**: entered from S_RUN when `halt_req` is 1.
- **S_HALT**: entered from S_DRAIN when all four valid bits are 0. Returns to S_RUN when `halt_req` falls.

Actions in S_RUN, highest priority first:
- **Freeze**, when `mem_busy` is 1:
  - All enables are 0 and no valid bit changes.
  - `stall_count` increments.
  - Takes effect the same cycle `mem_busy` first rises, before S_MEM_WAIT is registered.
- **Flush**, when `ex_valid && ex_branch_taken`:
  - All enables are 1 and `pc_load` is 1.
  - Next `ex_valid` is 0 and next `dec_valid` is 0, killing the instructions in decode and fetch.
  - `mem_valid` takes the old `ex_valid`.
- **Load-use bubble**, when `dec_valid && ex_valid && ex_mem_read && ex_reg_write` and a used decode source register equals `ex_reg_dest`:
  - `fetch_en` and `decode_en` are 0; `exec_en`, `mem_en` and `wb_en` are 1.
  - Next `ex_valid` is 0 and `dec_valid` holds.
  - `stall_count` increments.
- **Advance** otherwise:
  - All enables are 1.
  - Valid bits shift: `dec_valid` takes `if_valid`, `ex_valid` takes `dec_valid`, `mem_valid` takes `ex_valid`, `wb_valid` takes `mem_valid`.

Draining and halt:
- In S_DRAIN, `fetch_en` is 0 and the next `dec_valid` is 0 (no new instructions enter); downstream stages advance, and the flush and freeze rules still apply.
- In S_HALT, all enables are 0, `halted` is 1 and `pc_load` is 0.

Other rules:
- `stall_count` saturates at all-ones.
- Register compares use exactly REG_ADDR_W bits.
- Hazard detection is suppressed in the same cycle as a flush, because the decode instruction is being killed.
- `halt_req` arriving during S_MEM_WAIT is acted on only after the return to S_RUN.

## Timing

- While `rst` is 1, and on the cycle after it:
  - All enables and `pc_load` are 0.
  - All valid bits are 0; `halted` is 0; `stall_count` is 0; state is S_RESET.
- `rst` asserted mid-operation clears all of the above on the next edge, regardless of state.
- Enables and `pc_load` are combinational from the current state and inputs, with no added latency.
- Valid bits, state, `halted` and `stall_count` update on the edge that ends the cycle.
- A load-use bubble lasts exactly 1 cycle; on the following cycle the load is in the memory stage and the hazard condition is false.
- A taken branch costs 2 bubble cycles: the decode and execute valid bits are cleared.
- `mem_busy` held for N cycles freezes the pipe for exactly N cycles, and `stall_count` rises by N.
- A branch and `mem_busy` in the same cycle: the freeze wins. The branch is re-evaluated after the freeze, because `ex_valid` and `ex_branch_taken` are held.

## Structure

- The package `cpu_ctrl_pkg` holds:
  - the `ctrl_state_t` enum: S_RESET, S_RUN, S_MEM_WAIT, S_DRAIN, S_HALT;
  - the default register-address width constant, shared with the decoder.
- The sub-module `hazard_detect` is purely combinational: decode sources and use flags plus the execute load and destination fields produce a `load_use` signal.
- The top level holds the state register, the valid shift chain, the priority mux and the counter.

## Test plan

- **Reset:** hold `rst` high for 3 cycles with `if_valid`=1, then release. All enables are 0 for 3+1 cycles; `dec_valid` rises 1 cycle after `fetch_en` first rises; `wb_valid` reaches 1 four cycles later.
- **Load-use:** load to r2 in execute (`ex_mem_read`=1, `ex_reg_dest`=2), decode reads r2 with `dec_use1`=1. For 1 cycle `fetch_en`=`decode_en`=0 and `exec_en`=1; next `ex_valid`=0; `stall_count`=1. Repeat with `dec_use1`=0: no stall.
- **Branch flush:** pipe full, `ex_branch_taken`=1. `pc_load`=1 that cycle; next `dec_valid`=`ex_valid`=0 and `mem_valid`=1.
- **Memory wait:** hold `mem_busy` for 4 cycles with a simultaneous taken branch on the first. All enables are 0 for 4 cycles and valid bits are unchanged; `pc_load` fires on cycle 5; `stall_count` reads 4.
- **Halt and resume:** assert `halt_req` with a full pipe. `fetch_en`=0 immediately; `halted`=1 after the four valid bits clear (5 cycles). Drop `halt_req`: `fetch_en`=1 next cycle.
- **Saturation and mid-stall reset:** with `STALL_CNT_W`=4, hold `mem_busy` for 20 cycles; `stall_count` stops at 15. Assert `rst` during the stall; all outputs return to their reset values next cycle.
